reg_file_wb: RTL and testbench

- 16 x 32-bit CPU register file: one write-back port, two registered read ports.
- Sits in the write-back and operand-fetch path. Decodes the write address into the per-register one-hot Load enables that feed the 32-bit Register stage.
- Includes a one-entry write-back buffer so a write commits one cycle after it is presented.
- Reads that hit the pending buffer entry are forwarded, so operand fetch never sees stale data.

---
 rtl/reg_file_pkg.sv | 43 ++++
 rtl/reg_file_wb_register.sv | 29 ++
 rtl/reg_file_wb.sv | 94 +++++++++
 tb/tb_reg_file_wb.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg
// Shared types and constants for the 16 x 32-bit register file slice, plus
// the read-select/forward function used by both read ports.
// Optional feature macro: REGFILE_WR_BYPASS_EN (adds the incoming write as
// the highest-priority read source).

package reg_file_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [NUM_REGS-1:0][DATA_W-1:0] reg_array_t;

  localparam reg_data_t RESET_VAL = '0;

  // Value a read of address x must return this cycle. The pending buffer
  // entry has not reached the array yet, so it overrides the array; with the
  // bypass build the write being presented right now overrides both.
  function automatic reg_data_t read_sel(
    input reg_addr_t  x,
`ifdef REGFILE_WR_BYPASS_EN
    input logic       we,
    input reg_addr_t  wa,
    input reg_data_t  wd,
`endif
    input logic       wb_valid,
    input reg_addr_t  wb_addr,
    input reg_data_t  wb_data,
    input reg_array_t regs
  );
    reg_data_t r;
    r = regs[x];
    if (wb_valid && (wb_addr == x)) r = wb_data;
`ifdef REGFILE_WR_BYPASS_EN
    if (we && (wa == x)) r = wd;
`endif
    return r;
  endfunction

endpackage

// File: rtl/reg_file_wb_register.sv
// reg_file_wb_register
// One DATA_W-bit storage register with a load enable.
// Ports:
//   Clk   - system clock, rising edge
//   Reset - asynchronous active-low reset, clears Q to RESET_VAL
//   Load  - when high, Q takes IN at the rising edge
//   IN    - data to load
//   Q     - stored value

module reg_file_wb_register
  import reg_file_pkg::*;
(
  input  logic      Clk,
  input  logic      Reset,
  input  logic      Load,
  input  reg_data_t IN,
  output reg_data_t Q
);

  // Hold unless this register is the one selected by the write-back decode.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Q <= RESET_VAL;
    end else if (Load) begin
      Q <= IN;
    end
  end

endmodule

// File: rtl/reg_file_wb.sv
// reg_file_wb
// 16 x 32-bit register file with one write-back port, a one-entry write-back
// buffer (writes commit the cycle after they are presented) and two
// registered read ports that forward from the pending buffer entry.
// Optional feature macro: REGFILE_WR_BYPASS_EN -- when defined, a read of the
// address being written in the same cycle returns the incoming WD.
// Ports:
//   Clk       - system clock, rising edge
//   Reset     - asynchronous active-low reset
//   WE/WA/WD  - write request, address and data
//   RA/RB     - read addresses, ports A and B
//   OutA/OutB - registered read data (1-cycle latency)
//   WbPending - high while the write-back buffer holds an uncommitted write

module reg_file_wb
  import reg_file_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] WD,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  output logic [DATA_W-1:0] OutA,
  output logic [DATA_W-1:0] OutB,
  output logic              WbPending
);

  logic                wb_valid;
  reg_addr_t           wb_addr;
  reg_data_t           wb_data;
  logic [NUM_REGS-1:0] load;
  reg_array_t          regs;
  reg_data_t           next_a;
  reg_data_t           next_b;

  // Write-back buffer. A new write is captured in the same cycle the previous
  // one commits, so back-to-back writes flow at full rate with no stall.
  // Address/data are only reloaded for real writes.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= RESET_VAL;
    end else begin
      wb_valid <= WE;
      if (WE) begin
        wb_addr <= WA;
        wb_data <= WD;
      end
    end
  end

  assign WbPending = wb_valid;

  // One-hot load decode: only the buffered address's register is enabled.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
    assign load[i] = wb_valid && (wb_addr == reg_addr_t'(i));

    reg_file_wb_register u_reg (
      .Clk   (Clk),
      .Reset (Reset),
      .Load  (load[i]),
      .IN    (wb_data),
      .Q     (regs[i])
    );
  end

  always_comb begin
    next_a = read_sel(RA,
`ifdef REGFILE_WR_BYPASS_EN
                      WE, WA, WD,
`endif
                      wb_valid, wb_addr, wb_data, regs);
    next_b = read_sel(RB,
`ifdef REGFILE_WR_BYPASS_EN
                      WE, WA, WD,
`endif
                      wb_valid, wb_addr, wb_data, regs);
  end

  // Registered read ports.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      OutA <= RESET_VAL;
      OutB <= RESET_VAL;
    end else begin
      OutA <= next_a;
      OutB <= next_b;
    end
  end

endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb
// Scoreboard bench for reg_file_wb. Expected read data comes from an
// architectural model: a read sampled at an edge sees every write presented
// at earlier edges (plus, in the bypass build, the write at the same edge).

module tb_reg_file_wb;
  import reg_file_pkg::*;

  logic      Clk = 1'b0;
  logic      Reset = 1'b0;
  logic      WE = 1'b0;
  reg_addr_t WA = '0;
  reg_data_t WD = '0;
  reg_addr_t RA = '0;
  reg_addr_t RB = '0;
  reg_data_t OutA;
  reg_data_t OutB;
  logic      WbPending;

  always #5 Clk = ~Clk;

  reg_file_wb dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .WE        (WE),
    .WA        (WA),
    .WD        (WD),
    .RA        (RA),
    .RB        (RB),
    .OutA      (OutA),
    .OutB      (OutB),
    .WbPending (WbPending)
  );

`ifdef REGFILE_WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    reg_data_t a;
    reg_data_t b;
    logic      pend;
    string     tag;
  } exp_t;

  exp_t      expQ[$];
  reg_data_t model[NUM_REGS];
  bit        monEn = 1'b0;
  int        checks = 0;
  int        passes = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
  endtask

  // Drive one cycle of stimulus (called at a negedge) and record what the
  // outputs must show after the coming rising edge.
  task automatic applyStimulus(input logic we, input reg_addr_t wa, input reg_data_t wd,
                               input reg_addr_t ra, input reg_addr_t rb, input string tag);
    exp_t e;
    WE = we; WA = wa; WD = wd; RA = ra; RB = rb;
    e.a    = (BYPASS && we && wa == ra) ? wd : model[ra];
    e.b    = (BYPASS && we && wa == rb) ? wd : model[rb];
    e.pend = we;
    e.tag  = tag;
    expQ.push_back(e);
    if (we) model[wa] = wd;
    @(negedge Clk);
  endtask

  task automatic drain();
    int n = 0;
    WE = 1'b0;
    while (expQ.size() > 0 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (expQ.size() > 0) begin
      checks++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
      expQ.delete();
    end
  endtask

  // Monitor: the outputs are valid just after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (monEn && expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput({e.tag, " OutA"}, OutA, e.a);
        checkOutput({e.tag, " OutB"}, OutB, e.b);
        checkOutput({e.tag, " WbPending"}, {31'b0, WbPending}, {31'b0, e.pend});
      end
    end
  end

  initial begin
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

    // Power-up reset state.
    #12;
    checkOutput("reset OutA", OutA, 32'h0);
    checkOutput("reset OutB", OutB, 32'h0);
    checkOutput("reset WbPending", {31'b0, WbPending}, 32'h0);
    @(negedge Clk);
    Reset = 1'b1;
    monEn = 1'b1;

    // Sequential fill, then read back from both ends.
    for (int i = 0; i < NUM_REGS; i++)
      applyStimulus(1'b1, reg_addr_t'(i), reg_data_t'(i + 1), '0, '0, "fill");
    for (int i = 0; i < NUM_REGS; i++)
      applyStimulus(1'b0, '0, '0, reg_addr_t'(i), reg_addr_t'(15 - i), "readback");

    // Buffer forward: read the address one edge after its write.
    applyStimulus(1'b1, 4'd5, 32'h1234, 4'd0, 4'd1, "fwd-wr");
    applyStimulus(1'b0, 4'd0, 32'h0, 4'd5, 4'd5, "fwd-rd");

    // Same-cycle read/write.
    applyStimulus(1'b1, 4'd7, 32'h11, 4'd0, 4'd0, "same-init");
    applyStimulus(1'b0, 4'd0, 32'h0, 4'd0, 4'd0, "same-idle");
    applyStimulus(1'b0, 4'd0, 32'h0, 4'd0, 4'd0, "same-idle");
    applyStimulus(1'b1, 4'd7, 32'h22, 4'd7, 4'd7, "same-rw");
    applyStimulus(1'b0, 4'd0, 32'h0, 4'd7, 4'd7, "same-next");

    // Back-to-back writes to one address; pending stays high for two cycles.
    applyStimulus(1'b1, 4'd2, 32'h5, 4'd0, 4'd0, "b2b-1");
    applyStimulus(1'b1, 4'd2, 32'h6, 4'd2, 4'd0, "b2b-2");
    applyStimulus(1'b0, 4'd0, 32'h0, 4'd2, 4'd2, "b2b-rd1");
    applyStimulus(1'b0, 4'd0, 32'h0, 4'd2, 4'd2, "b2b-rd2");

    // Dual-port alias.
    applyStimulus(1'b1, 4'd9, 32'hDEADBEEF, 4'd0, 4'd0, "alias-wr");
    applyStimulus(1'b0, 4'd0, 32'h0, 4'd1, 4'd1, "alias-idle");
    applyStimulus(1'b0, 4'd0, 32'h0, 4'd9, 4'd9, "alias-rd");

    // Random traffic over the whole address space, including 0 and 15.
    for (int i = 0; i < 300; i++)
      applyStimulus(1'($urandom_range(0, 1)), reg_addr_t'($urandom_range(0, 15)),
                    reg_data_t'($urandom), reg_addr_t'($urandom_range(0, 15)),
                    reg_addr_t'($urandom_range(0, 15)), "random");

    // Make register 3 nonzero and visible on both outputs before reset.
    applyStimulus(1'b1, 4'd3, 32'hAA, 4'd0, 4'd0, "pre-rst-wr");
    applyStimulus(1'b0, 4'd0, 32'h0, 4'd3, 4'd3, "pre-rst-rd");
    drain();

    // Asynchronous reset mid-cycle with a write sitting in the buffer.
    monEn = 1'b0;
    WE = 1'b1; WA = 4'd3; WD = 32'hBB; RA = 4'd3; RB = 4'd3;
    @(posedge Clk);
    #2;
    checkOutput("pre-reset WbPending", {31'b0, WbPending}, 32'h1);
    Reset = 1'b0;
    #1;
    checkOutput("async reset OutA", OutA, 32'h0);
    checkOutput("async reset OutB", OutB, 32'h0);
    checkOutput("async reset WbPending", {31'b0, WbPending}, 32'h0);
    @(negedge Clk);
    WE = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    @(negedge Clk);
    Reset = 1'b1;
    monEn = 1'b1;
    applyStimulus(1'b0, 4'd0, 32'h0, 4'd3, 4'd3, "post-rst");
    applyStimulus(1'b0, 4'd0, 32'h0, 4'd0, 4'd15, "post-rst");
    applyStimulus(1'b0, 4'd0, 32'h0, 4'd7, 4'd9, "post-rst");
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got %0d checks, expected completion", checks);
    $fatal(1, "[TB] timeout");
  end

endmodule
